// File: rtl/arbitro_botoes_pkg.sv
// Shared definitions for the button arbiter: FSM encoding, 50 MHz
// debounce defaults and a small modular-increment helper.
package arbitro_botoes_pkg;

  // Arbiter states: idle (nothing offered) or offering an event.
  typedef enum logic [0:0] {
    OCIOSO = 1'b0,
    OFERTA = 1'b1
  } estado_e;

  // 10 ms of stable level at 50 MHz.
  localparam int DEBOUNCE_CICLOS_50MHZ = 500_000;
  localparam int CONT_W_50MHZ          = 20;

  // Next index after idx in a ring of n entries.
  function automatic int prox_indice(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/arbitro_botoes_debounce_canal.sv
// One button channel: 2-flop synchronizer, level debouncer and a
// press pulse (rising edge of the debounced level).
module debounce_canal
  import arbitro_botoes_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_50MHZ,
  parameter int CONT_W          = CONT_W_50MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao_i,
  output logic pulso_o
);

  localparam logic [CONT_W-1:0] LIMITE = CONT_W'(DEBOUNCE_CICLOS - 1);

  logic              sinc1_q;
  logic              sinc_q;
  logic              estavel_q;
  logic              estavel_d;
  logic              estavel_ant_q;
  logic [CONT_W-1:0] cont_q;
  logic [CONT_W-1:0] cont_d;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc1_q <= 1'b0;
      sinc_q  <= 1'b0;
    end else begin
      sinc1_q <= botao_i;
      sinc_q  <= sinc1_q;
    end
  end

  // Count how long the synchronized level has differed from the accepted
  // one; accept it after the full window, restart on any return.
  always_comb begin
    cont_d    = cont_q;
    estavel_d = estavel_q;
    if (sinc_q != estavel_q) begin
      if (cont_q == LIMITE) begin
        estavel_d = sinc_q;
        cont_d    = '0;
      end else begin
        cont_d = cont_q + CONT_W'(1);
      end
    end else begin
      cont_d = '0;
    end
  end

  // Debounce state plus the one-cycle-delayed copy used for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q        <= '0;
      estavel_q     <= 1'b0;
      estavel_ant_q <= 1'b0;
    end else begin
      cont_q        <= cont_d;
      estavel_q     <= estavel_d;
      estavel_ant_q <= estavel_q;
    end
  end

  // Press pulse is decoded straight from two flops (glitch-free), so the
  // pending bit can be set on the very next edge after the level settles.
  assign pulso_o = estavel_q & ~estavel_ant_q;

endmodule

// File: rtl/arbitro_botoes.sv
// Multi-button controller: debounces N buttons, latches each press as a
// pending request and hands them out one per transfer in round-robin order.
module arbitro_botoes
  import arbitro_botoes_pkg::*;
#(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_50MHZ,
  parameter int CONT_W          = CONT_W_50MHZ,
  parameter int ID_W            = $clog2(N_BOTOES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                evento_valid,
  output logic [ID_W-1:0]     evento_id,
  input  logic                evento_ready,
  output logic [N_BOTOES-1:0] pendentes,
  output logic [N_BOTOES-1:0] overrun
);

  logic [N_BOTOES-1:0] pulso_s;
  logic [N_BOTOES-1:0] pend_q;
  logic [N_BOTOES-1:0] pend_d;
  logic [N_BOTOES-1:0] ovr_q;
  logic [N_BOTOES-1:0] ovr_d;
  logic [N_BOTOES-1:0] conc_s;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     ptr_d;
  logic [ID_W-1:0]     id_q;
  logic [ID_W-1:0]     id_d;
  logic [ID_W-1:0]     alvo_s;
  logic [ID_W-1:0]     idx_s;
  logic                achou_s;
  logic                conceder_s;
  logic                valid_q;
  logic                valid_d;
  estado_e             estado_q;
  estado_e             estado_d;

  genvar g;
  generate
    for (g = 0; g < N_BOTOES; g++) begin : g_canal
      debounce_canal #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
        .CONT_W         (CONT_W)
      ) u_canal (
        .clk    (clk),
        .rst_n  (rst_n),
        .botao_i(botoes[g]),
        .pulso_o(pulso_s[g])
      );
    end
  endgenerate

  // Round-robin search: first pending channel at or above ptr, with wrap.
  always_comb begin
    achou_s = 1'b0;
    alvo_s  = '0;
    idx_s   = '0;
    for (int off = 0; off < N_BOTOES; off++) begin
      idx_s = ID_W'((int'(ptr_q) + off) % N_BOTOES);
      if (!achou_s && pend_q[idx_s]) begin
        achou_s = 1'b1;
        alvo_s  = idx_s;
      end else begin
        achou_s = achou_s;
      end
    end
  end

  // Arbiter next state, grant decision and pending/overrun update.
  always_comb begin
    estado_d   = estado_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    conceder_s = 1'b0;
    conc_s     = '0;
    case (estado_q)
      OCIOSO: begin
        if (achou_s) begin
          conceder_s = 1'b1;
          estado_d   = OFERTA;
        end else begin
          estado_d = OCIOSO;
        end
      end
      OFERTA: begin
        if (evento_ready) begin
          if (achou_s) begin
            conceder_s = 1'b1;
            estado_d   = OFERTA;
          end else begin
            estado_d = OCIOSO;
          end
        end else begin
          estado_d = OFERTA;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    if (conceder_s) begin
      id_d   = alvo_s;
      ptr_d  = ID_W'(prox_indice(int'(alvo_s), N_BOTOES));
      conc_s = N_BOTOES'(1) << alvo_s;
    end else begin
      id_d = id_q;
    end

    // A press landing on the grant cycle simply re-arms the bit.
    pend_d  = (pend_q & ~conc_s) | pulso_s;
    ovr_d   = pulso_s & pend_q & ~conc_s;
    valid_d = (estado_d == OFERTA);
  end

  // Arbiter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      id_q     <= '0;
      ptr_q    <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      valid_q  <= valid_d;
    end
  end

  assign evento_valid = valid_q;
  assign evento_id    = id_q;
  assign pendentes    = pend_q;
  assign overrun      = ovr_q;

endmodule
